vend_buyer: RTL and testbench

//  Customer-side coin sequencer that drives the drink vending machine
//  (inputs d1/d2/sel) and checks what comes back (out1/out2/out3).
//  A purchase request is turned into a timed train of 0.5/1 coin pulses.
//  The block then waits for the dispense response and reports the drink

---
 rtl/vend_buyer.sv | 151 +++++++++++++++
 tb/tb_vend_buyer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vend_buyer.sv
// rtl/vend_buyer.sv - customer-side coin sequencer and dispense checker for the drink vending machine
module vend_buyer #(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_sel,
  input  logic       req_big,
  output logic       d1,
  output logic       d2,
  output logic       sel,
  input  logic       out1,
  input  logic       out2,
  input  logic       out3,
  output logic       done,
  output logic [1:0] got_drink,
  output logic       change,
  output logic [1:0] err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_COIN = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state;
  logic [2:0] price;
  logic [2:0] paid;
  logic [2:0] gap_cnt;
  logic [7:0] wait_cnt;
  logic       big;
  logic       early;

  logic [2:0] paid_next;
  logic [2:0] coin_base;
  logic [2:0] remaining;
  logic       last_coin;
  logic       next_big;
  logic [1:0] exp_drink;
  logic       exp_change;
  logic       mismatch;

  // The coin register is loaded on the edge entering COIN, so the next
  // coin is chosen from the paid total as it will stand after this cycle.
  always_comb begin
    paid_next  = paid + (d2 ? 3'd2 : 3'd1);
    last_coin  = (paid_next >= price);
    coin_base  = (state == S_COIN) ? paid_next : paid;
    remaining  = price - coin_base;
    next_big   = big || (remaining >= 3'd2);
    exp_drink  = sel ? 2'b10 : 2'b01;
    exp_change = ((paid - price) == 3'd1);
    mismatch   = early || ({out2, out1} != exp_drink) || (out3 != exp_change);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      price     <= 3'd0;
      paid      <= 3'd0;
      gap_cnt   <= 3'd0;
      wait_cnt  <= 8'd0;
      big       <= 1'b0;
      early     <= 1'b0;
      req_ready <= 1'b1;
      d1        <= 1'b0;
      d2        <= 1'b0;
      sel       <= 1'b0;
      done      <= 1'b0;
      got_drink <= 2'b00;
      change    <= 1'b0;
      err       <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            sel       <= req_sel;
            price     <= req_sel ? 3'd5 : 3'd3;
            big       <= req_big;
            paid      <= 3'd0;
            early     <= 1'b0;
            req_ready <= 1'b0;
            got_drink <= 2'b00;
            change    <= 1'b0;
            err       <= 2'b00;
            // Both prices are at least 2 halves, so the first coin is always a 1.0.
            d2        <= 1'b1;
            d1        <= 1'b0;
            state     <= S_COIN;
          end
        end
        S_COIN: begin
          if (out1 || out2) early <= 1'b1;
          paid <= paid_next;
          if (last_coin) begin
            d1       <= 1'b0;
            d2       <= 1'b0;
            wait_cnt <= 8'd0;
            state    <= S_WAIT;
          end else if (GAP == 0) begin
            d2 <= next_big;
            d1 <= ~next_big;
          end else begin
            d1      <= 1'b0;
            d2      <= 1'b0;
            gap_cnt <= 3'd0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (out1 || out2) early <= 1'b1;
          if (gap_cnt == 3'(GAP - 1)) begin
            d2    <= next_big;
            d1    <= ~next_big;
            state <= S_COIN;
          end else begin
            gap_cnt <= gap_cnt + 3'd1;
          end
        end
        S_WAIT: begin
          if (out1 || out2) begin
            got_drink <= {out2, out1};
            change    <= out3;
            err       <= mismatch ? 2'b01 : 2'b00;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            got_drink <= 2'b00;
            change    <= 1'b0;
            err       <= 2'b10;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_buyer.sv
// tb/tb_vend_buyer.sv - randomized self-checking bench for vend_buyer against a purchase-level model
module tb_vend_buyer;
  localparam int GAP = 1;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0, req_sel = 1'b0, req_big = 1'b0;
  logic       out1 = 1'b0, out2 = 1'b0, out3 = 1'b0;
  logic       req_ready, d1, d2, sel, done, change;
  logic [1:0] got_drink, err;

  int total = 0;
  int bad = 0;
  int obs_paid = 0;
  bit chk_en = 0;
  bit noise = 0;

  logic       e_ready = 1'b1, e_d1 = 1'b0, e_d2 = 1'b0, e_sel = 1'b0, e_done = 1'b0, e_chg = 1'b0;
  logic [1:0] e_got = 2'b00, e_err = 2'b00;

  vend_buyer #(.GAP(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_big(req_big), .d1(d1), .d2(d2), .sel(sel),
    .out1(out1), .out2(out2), .out3(out3), .done(done),
    .got_drink(got_drink), .change(change), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({req_ready, d1, d2, sel, done, got_drink, change, err} !==
          {e_ready, e_d1, e_d2, e_sel, e_done, e_got, e_chg, e_err}) begin
        bad++;
        $display("FAIL cycle t=%0t ready/d1/d2/sel/done/got/chg/err actual %b %b %b %b %b %b %b %b required %b %b %b %b %b %b %b %b",
                 $time, req_ready, d1, d2, sel, done, got_drink, change, err,
                 e_ready, e_d1, e_d2, e_sel, e_done, e_got, e_chg, e_err);
      end
      obs_paid += int'(d1) + 2 * int'(d2);
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (noise) req_valid = 1'($urandom_range(0, 1));
  endtask

  function automatic int model_paid(input bit s, input bit b);
    int price = s ? 5 : 3;
    int p = 0;
    while (p < price) p += (b || price - p >= 2) ? 2 : 1;
    return p;
  endfunction

  task automatic purchase(input bit s, input bit b, input int resp_k,
                          input bit wd, input bit wc, input bit early);
    int coins[$];
    int price, p, c;
    bit exp_c, responded;
    logic [1:0] drive_got;
    logic drive_chg;
    price = s ? 5 : 3;
    p = 0;
    while (p < price) begin
      c = (b || price - p >= 2) ? 2 : 1;
      coins.push_back(c);
      p += c;
    end
    exp_c = (p - price == 1);
    req_valid = 1'b1; req_sel = s; req_big = b;
    step();
    req_valid = 1'b0; obs_paid = 0; noise = 1;
    req_sel = 1'($urandom_range(0, 1)); req_big = 1'($urandom_range(0, 1));
    e_ready = 1'b0; e_sel = s; e_got = 2'b00; e_chg = 1'b0; e_err = 2'b00;
    foreach (coins[i]) begin
      e_d1 = (coins[i] == 1); e_d2 = (coins[i] == 2);
      if (early && i == 0) out1 = 1'b1;
      step();
      out1 = 1'b0; e_d1 = 1'b0; e_d2 = 1'b0;
      if (i != coins.size() - 1) repeat (GAP) step();
    end
    drive_got = s ? 2'b10 : 2'b01;
    if (wd) drive_got = ~drive_got;
    drive_chg = exp_c ^ wc;
    responded = 0;
    for (int k = 0; k < TO; k++) begin
      if (k == resp_k) begin
        {out2, out1} = drive_got; out3 = drive_chg; responded = 1;
      end
      step();
      out1 = 1'b0; out2 = 1'b0; out3 = 1'b0;
      if (responded) break;
    end
    e_done = 1'b1;
    if (responded) begin
      e_got = drive_got; e_chg = drive_chg; e_err = (early || wd || wc) ? 2'b01 : 2'b00;
    end else begin
      e_got = 2'b00; e_chg = 1'b0; e_err = 2'b10;
    end
    noise = 0; req_valid = 1'b0;
    step();
    e_done = 1'b0; e_ready = 1'b1;
  endtask

  initial begin
    repeat (2) step();
    chk_en = 1;
    step();
    rst = 1'b1;
    step();

    check("model_paid_d1", model_paid(0, 0), 3);
    check("model_paid_d1_big", model_paid(0, 1), 4);
    check("model_paid_d2", model_paid(1, 0), 5);
    check("model_paid_d2_big", model_paid(1, 1), 6);

    purchase(0, 0, 1, 0, 0, 0);
    check("t1_paid", obs_paid, 3); check("t1_got", int'(got_drink), 1);
    check("t1_chg", int'(change), 0); check("t1_err", int'(err), 0);
    purchase(0, 1, 0, 0, 0, 0);
    check("t2_paid", obs_paid, 4); check("t2_chg", int'(change), 1);
    purchase(1, 0, 2, 0, 0, 0);
    check("t3_paid", obs_paid, 5); check("t3_got", int'(got_drink), 2);
    purchase(1, 1, 0, 0, 0, 0);
    check("t4_paid", obs_paid, 6); check("t4_chg", int'(change), 1);
    purchase(0, 0, TO, 0, 0, 0);
    check("t5_err", int'(err), 2); check("t5_got", int'(got_drink), 0);

    // Mid-purchase reset between the first and second coin.
    req_valid = 1'b1; req_sel = 1'b1; req_big = 1'b0;
    step();
    req_valid = 1'b0;
    e_ready = 1'b0; e_sel = 1'b1; e_d2 = 1'b1; e_got = 2'b00; e_chg = 1'b0; e_err = 2'b00;
    step();
    e_d2 = 1'b0;
    #1;
    rst = 1'b0; obs_paid = 0;
    e_ready = 1'b1; e_sel = 1'b0;
    step();
    rst = 1'b1;
    repeat (4) step();
    check("t6_no_coins", obs_paid, 0);
    purchase(1, 0, 1, 0, 0, 0);
    check("t6_after_paid", obs_paid, 5);

    for (int n = 0; n < 40; n++) begin
      purchase(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9),
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 3)) step();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
